ip_job_sequencer: RTL

//  Single-beat AXI master that runs one job on the IP accelerator slave. Per job: stream N input words into

---
 rtl/ip_seq_pkg.sv | 28 ++
 rtl/ip_seq_wdog.sv | 26 ++
 rtl/ip_job_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_seq_pkg.sv
// Shared types and constants for the IP job sequencer.
package ip_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_L_AW,
    ST_L_W,
    ST_L_B,
    ST_S_AW,
    ST_S_W,
    ST_S_B,
    ST_WAIT,
    ST_D_AR,
    ST_D_R
  } ip_seq_state_e;

  localparam logic [31:0] IP_INSTR_OFS   = 32'h4000;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [10:0] JOB_LEN_MAX    = 11'd1024;

  // A job needs at least one word and must fit the 1024-word SRAM windows.
  function automatic logic len_ok(input logic [10:0] len);
    return (len != 11'd0) && (len <= JOB_LEN_MAX);
  endfunction

endpackage

// File: rtl/ip_seq_wdog.sv
// Response watchdog: counts cycles spent waiting on the slave, cleared on
// every state change, flags expiry on the LIMIT-th consecutive waiting cycle.
module ip_seq_wdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Wait-cycle counter, restarted whenever the sequencer moves on.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)            cnt <= '0;
    else if (load)           cnt <= '0;
    else if (run && !expire) cnt <= cnt + CW'(1);
  end

  assign expire = run && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/ip_job_sequencer.sv
// Single-beat AXI master running one accelerator job:
//   load N words into SRAM0, write the instruction, wait, drain N results.
// Optional response watchdog: define IP_SEQ_TIMEOUT_EN.
module ip_job_sequencer
  import ip_seq_pkg::*;
#(
  parameter logic [31:0]      IP_BASE     = 32'h1000_0000,
  parameter int unsigned      ID_W        = 4,
  parameter logic [ID_W-1:0]  MST_ID      = ID_W'(2),
  parameter int unsigned      COMP_CYCLES = 64,
  parameter int unsigned      TMO_CYCLES  = 1024
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic [10:0]     job_len,
  input  logic [1:0]      job_instr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ID_W-1:0] AWID,
  output logic [31:0]     AWADDR,
  output logic [3:0]      AWLEN,
  output logic [2:0]      AWSIZE,
  output logic [1:0]      AWBURST,
  output logic            AWVALID,
  input  logic            AWREADY,
  output logic [31:0]     WDATA,
  output logic [3:0]      WSTRB,
  output logic            WLAST,
  output logic            WVALID,
  input  logic            WREADY,
  input  logic [ID_W-1:0] BID,
  input  logic [1:0]      BRESP,
  input  logic            BVALID,
  output logic            BREADY,
  output logic [ID_W-1:0] ARID,
  output logic [31:0]     ARADDR,
  output logic [3:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARVALID,
  input  logic            ARREADY,
  input  logic [ID_W-1:0] RID,
  input  logic [31:0]     RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RLAST,
  input  logic            RVALID,
  output logic            RREADY
);

  localparam int unsigned WCW = $clog2(COMP_CYCLES + 1);

  if (COMP_CYCLES < 1 || TMO_CYCLES < 1) begin : g_bad_cfg
    $error("ip_job_sequencer: COMP_CYCLES and TMO_CYCLES must be >= 1");
  end

  ip_seq_state_e  state, state_nxt;
  logic [9:0]     idx;
  logic [9:0]     len_m1;
  logic [1:0]     instr_q;
  logic           err_q;
  logic           done_q;
  logic [WCW-1:0] wcnt;
  logic           last;
  logic           b_hs;
  logic           r_hs;
  logic           tmo_expire;

  // Word address tracks the registered index, so it is stable while VALID is held.
  logic [31:0] word_addr;
  assign word_addr = IP_BASE + {20'b0, idx, 2'b00};
  assign last      = (idx == len_m1);

  // Single-beat, full-word transactions only.
  assign AWID    = MST_ID;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = AXI_SIZE_4B;
  assign AWBURST = AXI_BURST_INCR;
  assign WSTRB   = 4'hF;
  assign WLAST   = WVALID;
  assign ARID    = MST_ID;
  assign ARADDR  = word_addr;
  assign ARLEN   = 4'd0;
  assign ARSIZE  = AXI_SIZE_4B;
  assign ARBURST = AXI_BURST_INCR;

  assign busy = (state != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

`ifdef IP_SEQ_TIMEOUT_EN
  logic tmo_run;
  assign tmo_run = (state == ST_L_AW) || (state == ST_S_AW) || (state == ST_D_AR) ||
                   (state == ST_L_B)  || (state == ST_S_B)  || (state == ST_D_R);

  ip_seq_wdog #(.LIMIT(TMO_CYCLES)) u_wdog (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .load    (state_nxt != state),
    .run     (tmo_run),
    .expire  (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake outputs; AW and W never overlap.
  always_comb begin
    state_nxt = state;
    job_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = RDATA;
    AWVALID   = 1'b0;
    AWADDR    = word_addr;
    WVALID    = 1'b0;
    WDATA     = in_data;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    case (state)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid && len_ok(job_len)) state_nxt = ST_L_AW;
      end
      ST_L_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = ST_L_W;
      end
      ST_L_W: begin
        in_ready = WREADY;
        WVALID   = in_valid;
        if (in_valid && WREADY) state_nxt = ST_L_B;
      end
      ST_L_B: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = last ? ST_S_AW : ST_L_AW;
      end
      ST_S_AW: begin
        AWVALID = 1'b1;
        AWADDR  = IP_BASE + IP_INSTR_OFS;
        if (AWREADY) state_nxt = ST_S_W;
      end
      ST_S_W: begin
        WVALID = 1'b1;
        WDATA  = {30'b0, instr_q};
        if (WREADY) state_nxt = ST_S_B;
      end
      ST_S_B: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Counter holds the cycles still to spend here, this one included.
        if (wcnt == WCW'(1)) state_nxt = ST_D_AR;
      end
      ST_D_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = ST_D_R;
      end
      ST_D_R: begin
        RREADY    = out_ready;
        out_valid = RVALID;
        if (RVALID && out_ready) state_nxt = last ? ST_IDLE : ST_D_AR;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abandon the job: drop every handshake so nothing half-completes.
    if (tmo_expire) begin
      state_nxt = ST_IDLE;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      AWVALID   = 1'b0;
      WVALID    = 1'b0;
      BREADY    = 1'b0;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
    end
    b_hs = BVALID && BREADY;
    r_hs = RVALID && RREADY;
  end

  // Job context: index, length, sticky error, wait counter and done pulse.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      idx     <= '0;
      len_m1  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      wcnt    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (job_valid) begin
            idx     <= '0;
            len_m1  <= 10'(job_len - 11'd1);
            instr_q <= job_instr;
            // Illegal length: report immediately, no bus traffic.
            err_q   <= !len_ok(job_len);
            done_q  <= !len_ok(job_len);
          end
        end
        ST_L_B, ST_S_B: begin
          if (b_hs) begin
            if (BRESP != AXI_RESP_OKAY || BID != MST_ID) err_q <= 1'b1;
            if (state == ST_L_B && !last) idx <= idx + 10'd1;
            if (state == ST_S_B) wcnt <= WCW'(COMP_CYCLES);
          end
        end
        ST_WAIT: begin
          wcnt <= wcnt - WCW'(1);
          idx  <= '0;
        end
        ST_D_R: begin
          if (r_hs) begin
            if (RRESP != AXI_RESP_OKAY || RID != MST_ID || !RLAST) err_q <= 1'b1;
            if (last) done_q <= 1'b1;
            else      idx    <= idx + 10'd1;
          end
        end
        default: ;
      endcase
      if (tmo_expire) begin
        done_q <= 1'b1;
        err_q  <= 1'b1;
      end
    end
  end

endmodule
